// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind a UART receiver: circular buffer with first-word-fall-through
// head, registered occupancy count and a sticky overflow flag for dropped words.
module uart_rx_fifo #(
  parameter int dbit   = 8,
  parameter int addr_w = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [dbit-1:0]   w_data,
  input  logic              rd,
  output logic [dbit-1:0]   r_data,
  output logic              empty,
  output logic              full,
  output logic [addr_w:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int DEPTH = 1 << addr_w;
  localparam logic [addr_w:0] DEPTH_C = {1'b1, {addr_w{1'b0}}};

  logic [dbit-1:0]   mem_q [DEPTH];
  logic [addr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_w:0]   count_q,  count_d;
  logic              ovf_q,    ovf_d;
  logic              rd_acc, wr_acc, drop;

  // Handshake: wr is a one-cycle strobe, w_data sampled with it; a word is accepted
  // unless full, where it is accepted only alongside an accepted rd. rd pops the
  // head when not empty and is ignored otherwise.
  always_comb begin
    rd_acc   = rd && (count_q != '0);
    wr_acc   = wr && ((count_q != DEPTH_C) || rd_acc);
    drop     = wr && !wr_acc;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
    else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    // A fresh drop outranks a clear in the same cycle.
    if (drop) ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately unreset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= w_data;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign r_data   = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at depth 4, 8-bit words.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset_n;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overflow;
  logic       clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.dbit(8), .addr_w(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr       (wr),
    .w_data   (w_data),
    .rd       (rd),
    .r_data   (r_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr = 1'b1; w_data = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, 32'(r_data), 32'(e));
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; wr = 1'b0; rd = 1'b0; clr_ovf = 1'b0; w_data = 8'h00;
    repeat (2) tick();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_rdata", 32'(r_data), 32'd0);
    reset_n = 1'b1;
    tick();

    // single word in and out
    push(8'h41);
    check("one_empty", 32'(empty), 32'd0);
    check("one_count", 32'(count), 32'd1);
    check("one_rdata", 32'(r_data), 32'h41);
    rd = 1'b1; tick(); rd = 1'b0;
    check("one_pop_empty", 32'(empty), 32'd1);
    check("one_pop_count", 32'(count), 32'd0);
    check("one_pop_rdata", 32'(r_data), 32'd0);

    // fill, overflow drop, drain in order
    for (int i = 1; i <= 4; i++) begin
      push(8'(i));
      exp_q.push_back(8'(i));
    end
    check("fill_full",  32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    check("fill_ovf",   32'(overflow), 32'd0);
    push(8'h05);
    check("drop_ovf",   32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd4);
    check("drop_head",  32'(r_data), 32'h01);
    for (int i = 0; i < 4; i++) pop_check("drain");
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_rdata", 32'(r_data), 32'd0);
    check("drain_ovf",   32'(overflow), 32'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);

    // simultaneous write and read while full
    for (int i = 1; i <= 4; i++) begin
      push(8'(i));
      exp_q.push_back(8'(i));
    end
    wr = 1'b1; w_data = 8'hAA; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'hAA);
    check("fullrw_count", 32'(count), 32'd4);
    check("fullrw_ovf",   32'(overflow), 32'd0);
    check("fullrw_head",  32'(r_data), 32'h02);
    for (int i = 0; i < 4; i++) pop_check("fullrw");
    check("fullrw_empty", 32'(empty), 32'd1);

    // simultaneous write and read while empty, then rd on empty
    wr = 1'b1; w_data = 8'h5A; rd = 1'b1;
    tick();
    wr = 1'b0; rd = 1'b0;
    check("emptyrw_count", 32'(count), 32'd1);
    check("emptyrw_rdata", 32'(r_data), 32'h5A);
    exp_q.push_back(8'h5A);
    pop_check("emptyrw");
    rd = 1'b1; tick(); rd = 1'b0;
    check("rd_empty_count", 32'(count), 32'd0);
    check("rd_empty_flag",  32'(empty), 32'd1);
    check("rd_empty_rdata", 32'(r_data), 32'd0);

    // pointer wrap: ten pairs through four slots, two words in flight
    push(8'h10);
    exp_q.push_back(8'h10);
    for (int i = 1; i < 10; i++) begin
      push(8'(8'h10 + i));
      exp_q.push_back(8'(8'h10 + i));
      pop_check("wrap");
    end
    pop_check("wrap");
    check("wrap_count", 32'(count), 32'd0);
    check("wrap_empty", 32'(empty), 32'd1);

    // set wins over clear, then clear alone
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h61 + i));
      exp_q.push_back(8'(8'h61 + i));
    end
    push(8'h65);
    check("ovf2_set", 32'(overflow), 32'd1);
    wr = 1'b1; w_data = 8'h66; clr_ovf = 1'b1;
    tick();
    wr = 1'b0; clr_ovf = 1'b0;
    check("ovf2_setwins", 32'(overflow), 32'd1);
    check("ovf2_count",   32'(count), 32'd4);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("ovf2_clr", 32'(overflow), 32'd0);
    pop_check("pre_rst");
    check("pre_rst_count", 32'(count), 32'd3);

    // asynchronous reset mid-operation, inputs ignored during reset
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_count", 32'(count), 32'd0);
    check("arst_rdata", 32'(r_data), 32'd0);
    exp_q.delete();
    wr = 1'b1; w_data = 8'hEE; clr_ovf = 1'b1;
    tick();
    wr = 1'b0; clr_ovf = 1'b0;
    check("inrst_count", 32'(count), 32'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_count", 32'(count), 32'd0);
    push(8'h77); exp_q.push_back(8'h77);
    push(8'h78); exp_q.push_back(8'h78);
    pop_check("post_rst");
    pop_check("post_rst");
    check("post_rst_empty", 32'(empty), 32'd1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
